delay_scan_ctrl: RTL and testbench
==================================

# delay_scan_ctrl

Shot-synchronous delay sweep sequencer for the pulse generator. It steps the echo delay handed to the pulse timing block through a programmed number of points. It holds each point for a programmed number of averaging shots, counted on rising edges of the Sync pulse. Parameter changes land only at a Sync edge, so no shot ever sees a delay that changed mid-period.

## Interface
Parameters:
- DW, 16: width of delay, step and output delay values.
- CW, 16: width of point and shot counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a scan; ignored unless idle.
- abort  in  1  level; terminates any scan.
- base_del  in  DW  delay value for point 0.
- step_del  in  DW  increment applied between points.
- n_points  in  CW  number of delay points; 0 is treated as 1.
- n_avg  in  CW  shots per point; 0 is treated as 1.
- sync_in  in  1  Sync output of the pulse timing block, synchronous to clk.
- del_out  out  DW  delay presented to the pulse timing block.
- point_idx  out  CW  current point, 0-based.
- shot_cnt  out  CW  shots completed at the current point.
- upd  out  1  one-cycle strobe when del_out changes.
- busy  out  1  high in ARM and RUN.
- done  out  1  one-cycle strobe at normal scan completion.

## Operation
- States: IDLE, ARM, RUN, DONE.
- Sync edge: sync_e = sync_in & ~sync_q, where sync_q is sync_in registered.
- IDLE, on start:
  - Latch base_del, step_del, n_points, n_avg (zero replaced by 1).
  - Set del_out=base_del, point_idx=0, shot_cnt=0, upd=1. Go to ARM.
  - Config inputs are not sampled again until the next start.
- ARM: first sync_e goes to RUN without counting a shot. That period may have started with the old delay.
- RUN, on sync_e:
  - If shot_cnt < n_avg-1: shot_cnt+1.
  - Otherwise, if point_idx < n_points-1: shot_cnt=0, point_idx+1, del_out += step, upd=1.
  - Otherwise: go to DONE. shot_cnt and point_idx hold their final values.
- DONE: assert done for one cycle, then go to IDLE.
- Output hold: del_out, point_idx and shot_cnt hold their values in IDLE until the next start.
- Arithmetic:
  - del_out addition is DW+1 wide and saturates at 2^DW-1; no wrap.
  - Counters never exceed their latched limit.
- abort overrides every state. The next state is IDLE, busy drops, and no done or upd is issued. Outputs hold.
- start together with abort: abort wins.
- start while busy: ignored.
- sync_e in the same cycle as start in IDLE: ignored. ARM begins next cycle.

## Timing
- Reset values: del_out=0, point_idx=0, shot_cnt=0, upd=0, busy=0, done=0. State is IDLE.
- start to outputs: del_out, upd and busy are valid one cycle after start is sampled.
- Sync to counters: sync_in rising at cycle N is seen as sync_e at cycle N. Counters, del_out and upd update at the clk edge ending cycle N and are visible in N+1.
- done is high for exactly one cycle, one cycle after the final sync_e. busy is low in that same cycle.
- Minimum Sync spacing: sync_in must stay low for at least one cycle between pulses. A sync_in held high counts once.
- Reset mid-scan: all outputs return to reset values immediately; no done.

## Configuration
- SCAN_DEC_EN defined:
  - Adds input dir (1 bit), latched at start.
  - dir=1 subtracts step_del per point, saturating at 0.
  - dir=0 behaves as below.
- SCAN_DEC_EN undefined: the dir port is absent and the scan only increments.

## Test plan
- Basic sweep:
  - Stimulus: base=100, step=10, n_points=3, n_avg=2; 7 Sync pulses after start.
  - Required: del_out sequence 100, 110, 120; upd count 3; done one cycle after the 7th Sync edge (the 1st is the ARM discard). Final point_idx=2, shot_cnt=1.
- Zero limits:
  - Stimulus: n_points=0, n_avg=0, base=5.
  - Required: done after the 2nd Sync edge; del_out stays 5; one upd only.
- Saturation:
  - Stimulus: DW=16, base=0xFFF0, step=0x20, n_points=3, n_avg=1.
  - Required: del_out = 0xFFF0, then 0xFFFF, then 0xFFFF.
- Abort:
  - Stimulus: assert abort during RUN at point 1.
  - Required: busy=0 next cycle; no done; del_out holds the point-1 value. Later Sync edges change nothing.
- Start while busy, and start with abort:
  - Stimulus: a second start mid-scan; start and abort in the same cycle.
  - Required: neither restarts or re-latches. Sequence identical to the basic sweep.
- With SCAN_DEC_EN:
  - Stimulus: dir=1, base=15, step=10, n_points=3, n_avg=1.
  - Required: del_out = 15, 5, 0.

Source files
------------

// File: rtl/delay_scan_ctrl.sv
// Sync-edge-synchronous delay sweep sequencer: steps del_out through n_points, n_avg shots each.
// Optional macro SCAN_DEC_EN adds a dir input selecting a saturating decrementing sweep.
module delay_scan_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] base_del,
  input  logic [DW-1:0] step_del,
  input  logic [CW-1:0] n_points,
  input  logic [CW-1:0] n_avg,
  input  logic          sync_in,
`ifdef SCAN_DEC_EN
  input  logic          dir,
`endif
  output logic [DW-1:0] del_out,
  output logic [CW-1:0] point_idx,
  output logic [CW-1:0] shot_cnt,
  output logic          upd,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          sync_q;
  logic          sync_e;
  logic [DW-1:0] step_q, step_d;
  logic [CW-1:0] pt_lim_q, pt_lim_d;
  logic [CW-1:0] avg_lim_q, avg_lim_d;
  logic          dec_q, dec_d;
  logic [DW-1:0] del_d;
  logic [CW-1:0] point_d, shot_d;
  logic          upd_d, busy_d, done_d;
  logic [DW:0]   sum;
  logic [DW-1:0] inc_del, dec_del, next_del;
  logic          last_shot, last_point;

  assign sync_e     = sync_in & ~sync_q;
  assign last_shot  = (shot_cnt >= avg_lim_q);
  assign last_point = (point_idx >= pt_lim_q);

  // Saturating step in either direction
  assign sum      = {1'b0, del_out} + {1'b0, step_q};
  assign inc_del  = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
  assign dec_del  = (step_q > del_out) ? DW'(0) : DW'(del_out - step_q);
  assign next_del = dec_q ? dec_del : inc_del;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ARM;
      S_ARM:   if (sync_e) state_d = S_RUN;
      S_RUN:   if (sync_e && last_shot && last_point) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Next values of registered outputs and latched scan configuration
  always_comb begin
    del_d     = del_out;
    point_d   = point_idx;
    shot_d    = shot_cnt;
    upd_d     = 1'b0;
    done_d    = 1'b0;
    step_d    = step_q;
    pt_lim_d  = pt_lim_q;
    avg_lim_d = avg_lim_q;
    dec_d     = dec_q;
    busy_d    = (state_d == S_ARM) || (state_d == S_RUN);
    if (!abort) begin
      unique case (state_q)
        S_IDLE: if (start) begin
          step_d    = step_del;
          pt_lim_d  = (n_points == CW'(0)) ? CW'(0) : CW'(n_points - CW'(1));
          avg_lim_d = (n_avg == CW'(0)) ? CW'(0) : CW'(n_avg - CW'(1));
`ifdef SCAN_DEC_EN
          dec_d     = dir;
`else
          dec_d     = 1'b0;
`endif
          del_d     = base_del;
          point_d   = CW'(0);
          shot_d    = CW'(0);
          upd_d     = 1'b1;
        end
        S_RUN: if (sync_e) begin
          if (!last_shot) begin
            shot_d = CW'(shot_cnt + CW'(1));
          end else if (!last_point) begin
            shot_d  = CW'(0);
            point_d = CW'(point_idx + CW'(1));
            del_d   = next_del;
            upd_d   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 1'b0;
      step_q    <= '0;
      pt_lim_q  <= '0;
      avg_lim_q <= '0;
      dec_q     <= 1'b0;
      del_out   <= '0;
      point_idx <= '0;
      shot_cnt  <= '0;
      upd       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sync_q    <= sync_in;
      step_q    <= step_d;
      pt_lim_q  <= pt_lim_d;
      avg_lim_q <= avg_lim_d;
      dec_q     <= dec_d;
      del_out   <= del_d;
      point_idx <= point_d;
      shot_cnt  <= shot_d;
      upd       <= upd_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_delay_scan_ctrl.sv
// Scoreboard bench for delay_scan_ctrl: a behavioural scan model queues expected upd/done
// events as stimulus is driven; a negedge monitor pops and compares them.
module tb_delay_scan_ctrl;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset, start, abort, sync_in;
  logic [DW-1:0] base_del, step_del;
  logic [CW-1:0] n_points, n_avg;
  logic          dir;
  logic [DW-1:0] del_out;
  logic [CW-1:0] point_idx, shot_cnt;
  logic          upd, busy, done;

  delay_scan_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_del(base_del), .step_del(step_del), .n_points(n_points), .n_avg(n_avg),
    .sync_in(sync_in),
`ifdef SCAN_DEC_EN
    .dir(dir),
`endif
    .del_out(del_out), .point_idx(point_idx), .shot_cnt(shot_cnt),
    .upd(upd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] del;
    logic [31:0] pi;
    logic [31:0] sc;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: 0 idle, 1 armed, 2 running
  int          m_st = 0;
  logic [31:0] m_del = 0, m_pi = 0, m_sc = 0, m_step = 0, m_np = 1, m_na = 1;
  bit          m_dec = 0;

  task automatic push(input bit d);
    ev_t e;
    e.is_done = d; e.del = m_del; e.pi = m_pi; e.sc = m_sc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [31:0] b, s, np, na, input bit ab, input bit dr);
    base_del = DW'(b); step_del = DW'(s); n_points = CW'(np); n_avg = CW'(na);
    dir = dr; start = 1'b1; abort = ab;
    if (ab) m_st = 0;
    else if (m_st == 0) begin
      m_st = 1; m_del = b; m_pi = 0; m_sc = 0; m_step = s;
      m_np = (np == 0) ? 1 : np; m_na = (na == 0) ? 1 : na;
`ifdef SCAN_DEC_EN
      m_dec = dr;
`else
      m_dec = 0;
`endif
      push(0);
    end
    tick();
    start = 1'b0; abort = 1'b0;
    check("busy_after_start", {31'd0, busy}, (m_st != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic shot(input int gap);
    sync_in = 1'b1;
    if (m_st == 1) m_st = 2;
    else if (m_st == 2) begin
      if (m_sc < m_na - 1) m_sc++;
      else if (m_pi < m_np - 1) begin
        m_sc = 0; m_pi++;
        if (m_dec) m_del = (m_step > m_del) ? 0 : m_del - m_step;
        else m_del = (m_del + m_step > 32'hFFFF) ? 32'hFFFF : m_del + m_step;
        push(0);
      end else begin
        m_st = 0; push(1);
      end
    end
    tick();
    sync_in = 1'b0;
    repeat (gap) tick();
  endtask

  // Monitor: every upd/done strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && (upd || done)) begin
      if (exp_q.size() == 0) check(upd ? "unexpected_upd" : "unexpected_done", 32'd1, 32'd0);
      else begin
        ev_t e;
        e = exp_q.pop_front();
        check(upd ? "ev_upd" : "ev_done", {31'd0, done}, {31'd0, e.is_done});
        check("ev_del", 32'(del_out), e.del);
        check("ev_point", 32'(point_idx), e.pi);
        check("ev_shot", 32'(shot_cnt), e.sc);
        if (done) check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic drain(input string tag);
    repeat (3) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 0; abort = 0; sync_in = 0; dir = 0;
    base_del = 0; step_del = 0; n_points = 0; n_avg = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_del", 32'(del_out), 0);
    check("rst_point", 32'(point_idx), 0);
    check("rst_shot", 32'(shot_cnt), 0);
    check("rst_flags", {29'd0, upd, busy, done}, 0);

    // start with abort in the same cycle: nothing latched
    do_start(999, 1, 5, 5, 1'b1, 1'b0);
    check("start_abort_del", 32'(del_out), 0);
    tick();

    // Basic sweep, with a second start mid-scan that must be ignored
    do_start(100, 10, 3, 2, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      shot(2);
      if (i == 2) do_start(500, 50, 9, 9, 1'b0, 1'b0);
    end
    drain("basic_drain");
    check("basic_final_del", 32'(del_out), 120);
    check("basic_final_point", 32'(point_idx), 2);
    check("basic_final_shot", 32'(shot_cnt), 1);
    check("basic_done_width", {31'd0, done}, 0);

    // Zero limits
    do_start(5, 3, 0, 0, 1'b0, 1'b0);
    shot(2); shot(2);
    drain("zero_drain");
    check("zero_del", 32'(del_out), 5);

    // Saturation
    do_start(32'hFFF0, 32'h20, 3, 1, 1'b0, 1'b0);
    repeat (4) shot(1);
    drain("sat_drain");
    check("sat_del", 32'(del_out), 32'hFFFF);

    // Abort at point 1, later Sync edges are ignored
    do_start(200, 7, 4, 2, 1'b0, 1'b0);
    repeat (3) shot(2);
    abort = 1'b1; m_st = 0;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_del", 32'(del_out), 207);
    repeat (3) shot(2);
    drain("abort_drain");
    check("abort_point_hold", 32'(point_idx), 1);
    check("abort_del_hold", 32'(del_out), 207);

`ifdef SCAN_DEC_EN
    do_start(15, 10, 3, 1, 1'b0, 1'b1);
    repeat (4) shot(1);
    drain("dec_drain");
    check("dec_del", 32'(del_out), 0);
`endif

    // Reset mid-scan clears outputs at once
    do_start(300, 1, 5, 5, 1'b0, 1'b0);
    shot(2); shot(2);
    reset = 1'b1;
    #2;
    check("midrst_del", 32'(del_out), 0);
    check("midrst_shot", 32'(shot_cnt), 0);
    check("midrst_flags", {29'd0, upd, busy, done}, 0);
    m_st = 0; m_del = 0; m_pi = 0; m_sc = 0;
    tick();
    reset = 1'b0;
    shot(2);
    drain("midrst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
